// File: rtl/shift_pipe.sv
// shift_pipe: pipelined multi-mode barrel shifter with valid/ready handshakes.
//
// One log-shifter stage per shift-count bit. Stage k shifts or rotates by 2^k
// when count bit k is set. A stage refills from its predecessor whenever it is
// empty or emptying, so bubbles collapse even while the output is stalled.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   in_data, in_cnt     operand and shift amount (0..WIDTH-1)
//   in_mode             000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal
//   in_tag              sideband id carried unmodified to out_tag
//   out_valid/out_ready downstream handshake
//   out_data, out_tag   result and the tag of the op that produced it
//   out_err             op had an illegal mode (data passed through unshifted)
//   busy                any stage holds an op
module shift_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    localparam logic [2:0] MODE_SLL = 3'd0;
    localparam logic [2:0] MODE_SRL = 3'd1;
    localparam logic [2:0] MODE_SRA = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    // Stage registers; index k is the register after stage k.
    logic [CNT_W-1:0] vld_p;
    logic [WIDTH-1:0] data_p [CNT_W];
    logic [2:0]       mode_p [CNT_W];
    logic [CNT_W-1:0] cnt_p  [CNT_W];
    logic [TAG_W-1:0] tag_p  [CNT_W];
    logic [CNT_W-1:0] err_p;
    logic [CNT_W-1:0] sgn_p;

    // Inputs feeding each stage (the block inputs for stage 0).
    logic [CNT_W-1:0] src_vld;
    logic [WIDTH-1:0] src_data [CNT_W];
    logic [2:0]       src_mode [CNT_W];
    logic [CNT_W-1:0] src_cnt  [CNT_W];
    logic [TAG_W-1:0] src_tag  [CNT_W];
    logic [CNT_W-1:0] src_err;
    logic [CNT_W-1:0] src_sgn;

    logic [CNT_W-1:0] adv_p;
    logic [CNT_W-1:0] ld_p;

    // Shift/rotate by a fixed power-of-two amount. SRA fills with the original
    // operand MSB (sgn), not the current MSB, so the fill is correct at every
    // stage. amt never exceeds WIDTH/2, so WIDTH-amt is always a legal shift.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       m,
        input logic             sgn,
        input int               amt
    );
        logic [WIDTH-1:0] fill;
        fill = sgn ? ~({WIDTH{1'b1}} >> amt) : '0;
        case (m)
            MODE_SLL: shift_step = d << amt;
            MODE_SRL: shift_step = d >> amt;
            MODE_SRA: shift_step = (d >> amt) | fill;
            MODE_ROL: shift_step = (d << amt) | (d >> (WIDTH - amt));
            MODE_ROR: shift_step = (d >> amt) | (d << (WIDTH - amt));
            default:  shift_step = d;
        endcase
    endfunction

    // Advance chain, evaluated from the output back: a stage moves on when it
    // is full and its successor is empty or itself moving on.
    always_comb begin
        adv_p = '0;
        adv_p[CNT_W-1] = vld_p[CNT_W-1] & out_ready;
        for (int k = CNT_W - 2; k >= 0; k--) begin
            adv_p[k] = vld_p[k] & (~vld_p[k+1] | adv_p[k+1]);
        end
        ld_p = ~vld_p | adv_p;
    end

    always_comb begin
        src_vld     = '0;
        src_err     = '0;
        src_sgn     = '0;
        src_vld[0]  = in_valid;
        src_data[0] = in_data;
        src_mode[0] = in_mode;
        src_cnt[0]  = in_cnt;
        src_tag[0]  = in_tag;
        src_err[0]  = (in_mode > MODE_ROR);
        src_sgn[0]  = in_data[WIDTH-1];
        for (int k = 1; k < CNT_W; k++) begin
            src_vld[k]  = vld_p[k-1];
            src_data[k] = data_p[k-1];
            src_mode[k] = mode_p[k-1];
            src_cnt[k]  = cnt_p[k-1];
            src_tag[k]  = tag_p[k-1];
            src_err[k]  = err_p[k-1];
            src_sgn[k]  = sgn_p[k-1];
        end
    end

    // Stage k boundary: payload only updates when a real op arrives, so a
    // stalled or drained stage keeps its last value instead of toggling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
            err_p <= '0;
            sgn_p <= '0;
            for (int k = 0; k < CNT_W; k++) begin
                data_p[k] <= '0;
                mode_p[k] <= '0;
                cnt_p[k]  <= '0;
                tag_p[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < CNT_W; k++) begin
                if (ld_p[k]) begin
                    vld_p[k] <= src_vld[k];
                    if (src_vld[k]) begin
                        data_p[k] <= src_cnt[k][k]
                                   ? shift_step(src_data[k], src_mode[k], src_sgn[k], 1 << k)
                                   : src_data[k];
                        mode_p[k] <= src_mode[k];
                        cnt_p[k]  <= src_cnt[k];
                        tag_p[k]  <= src_tag[k];
                        err_p[k]  <= src_err[k];
                        sgn_p[k]  <= src_sgn[k];
                    end
                end
            end
        end
    end

    assign in_ready  = ld_p[0];
    assign out_valid = vld_p[CNT_W-1];
    assign out_data  = data_p[CNT_W-1];
    assign out_tag   = tag_p[CNT_W-1];
    assign out_err   = err_p[CNT_W-1];
    assign busy      = |vld_p;

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed and randomized checks of shift_pipe (WIDTH=16)
// against a queue-based reference model of the shifter.
module tb_shift_pipe;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [CNT_W-1:0] in_cnt = '0;
    logic [2:0]       in_mode = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic             busy;

    shift_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_cnt(in_cnt), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_err(out_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_out = 0;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  t;
        logic        e;
        int          c;
    } exp_t;

    exp_t        q[$];
    bit          lat_on = 1'b0;
    bit          hold_v = 1'b0;
    logic [20:0] hold_val = '0;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] c,
                                              input logic [2:0] m);
        logic [31:0] dd;
        logic [31:0] t;
        dd = {d, d};
        case (m)
            3'd0: return d << c;
            3'd1: return d >> c;
            3'd2: return $signed(d) >>> c;
            3'd3: begin t = dd << c; return t[31:16]; end
            3'd4: begin t = dd >> c; return t[15:0]; end
            default: return d;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard: every emitted result must match the oldest accepted op.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && out_valid)
                chk("hold_stable", 32'({out_data, out_tag, out_err}), 32'(hold_val));
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_tag", 32'(out_tag), 32'(e.t));
                    chk("out_err", 32'(out_err), 32'(e.e));
                    if (lat_on) chk("latency", cyc - e.c, CNT_W);
                end
            end
            if (in_valid && in_ready) begin
                e.d = ref_shift(in_data, in_cnt, in_mode);
                e.t = in_tag;
                e.e = (in_mode > 3'd4);
                e.c = cyc;
                q.push_back(e);
            end
            hold_v   = out_valid && !out_ready;
            hold_val = {out_data, out_tag, out_err};
        end
    end

    task automatic send(input logic [15:0] d, input logic [3:0] c, input logic [2:0] m,
                        input logic [3:0] t);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_cnt = c; in_mode = m; in_tag = t;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input logic [15:0] d, input logic [3:0] t, input logic e,
                            output int n);
        bit ok;
        ok = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (out_valid && out_ready) begin ok = 1'b1; break; end
        end
        chk("wait_out_seen", 32'(ok), 32'd1);
        chk("dir_data", 32'(out_data), 32'(d));
        chk("dir_tag", 32'(out_tag), 32'(t));
        chk("dir_err", 32'(out_err), 32'(e));
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc;
        int base;
        bit acc_last;
        logic [3:0] bt;

        // Reset state
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single ops, no backpressure
        out_ready = 1'b1;
        lat_on = 1'b1;
        send(16'h00F1, 4'd4, 3'd0, 4'd1);  wait_out(16'h0F10, 4'd1, 1'b0, n);
        send(16'h8001, 4'd15, 3'd1, 4'd2); wait_out(16'h0001, 4'd2, 1'b0, n);
        send(16'h8000, 4'd3, 3'd2, 4'd3);  wait_out(16'hF000, 4'd3, 1'b0, n);
        send(16'h8001, 4'd1, 3'd3, 4'd4);  wait_out(16'h0003, 4'd4, 1'b0, n);
        send(16'h0001, 4'd4, 3'd4, 4'd5);  wait_out(16'h1000, 4'd5, 1'b0, n);
        send(16'hBEEF, 4'd0, 3'd2, 4'd6);  wait_out(16'hBEEF, 4'd6, 1'b0, n);

        // Back-to-back stream
        fork
            begin
                for (int t = 0; t < 16; t++) send(16'h0001, 4'(t), 3'd0, 4'(t));
            end
            begin
                int m;
                for (int t = 0; t < 16; t++) begin
                    wait_out(16'(1 << t), 4'(t), 1'b0, m);
                    if (t > 0) chk("stream_gap", m, 1);
                end
            end
        join
        wait_idle();

        // Illegal mode between legal neighbours
        fork
            begin
                send(16'h00FF, 4'd4, 3'd0, 4'd1);
                send(16'h1234, 4'd5, 3'b110, 4'd2);
                send(16'hF00F, 4'd4, 3'd4, 4'd3);
            end
            begin
                int m;
                wait_out(16'h0FF0, 4'd1, 1'b0, m);
                wait_out(16'h1234, 4'd2, 1'b1, m);
                wait_out(16'hFF00, 4'd3, 1'b0, m);
            end
        join
        wait_idle();

        // Backpressure: fill the pipe, then release
        lat_on = 1'b0;
        out_ready = 1'b0;
        acc = 0;
        bt = 4'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 16'hA5F0 ^ 16'(bt);
            in_cnt = bt; in_mode = 3'd1; in_tag = bt;
            @(negedge clk);
            if (in_ready) begin acc++; bt++; end
            @(posedge clk); #1;
        end
        chk("bp_accepted", acc, 4);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        base = n_out;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle();
        chk("bp_drained", n_out - base, 5);

        // Bubble collapse
        out_ready = 1'b0;
        send(16'h0003, 4'd2, 3'd0, 4'hA);
        repeat (2) @(posedge clk);
        #1;
        send(16'h0100, 4'd1, 3'd1, 4'hB);
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bub_a_valid", 32'(out_valid), 32'd1);
        chk("bub_a_tag", 32'(out_tag), 32'hA);
        chk("bub_a_data", 32'(out_data), 32'h000C);
        @(negedge clk);
        chk("bub_b_valid", 32'(out_valid), 32'd1);
        chk("bub_b_tag", 32'(out_tag), 32'hB);
        chk("bub_b_data", 32'(out_data), 32'h0080);
        @(posedge clk); #1;
        wait_idle();

        // Reset with ops in flight
        out_ready = 1'b0;
        send(16'h0001, 4'd0, 3'd0, 4'd5);
        send(16'h0002, 4'd0, 3'd0, 4'd6);
        send(16'h0003, 4'd0, 3'd0, 4'd7);
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_data", 32'(out_data), 32'd0);
        chk("async_rst_tag", 32'(out_tag), 32'd0);
        q.delete();
        @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        lat_on = 1'b1;
        fork
            send(16'hFFFF, 4'd8, 3'd1, 4'd9);
            wait_out(16'h00FF, 4'd9, 1'b0, n);
        join
        wait_idle();

        // Randomized traffic with random backpressure
        lat_on = 1'b0;
        acc_last = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!in_valid || acc_last) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 16'($urandom);
                in_cnt   = 4'($urandom);
                in_mode  = 3'($urandom_range(0, 7));
                in_tag   = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc_last = in_valid && in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        chk("rand_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
